perif_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the computer's peripheral window, downstream of the memory bus (selected by PERIF_select).
//  CPU stores (STUR/STURB) queue bytes into a FIFO. CPU loads read status and the baud divisor.
//  The block serialises each byte as 8N1 on tx_out, so programs can emit output without polling every bit.

---
 rtl/perif_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_perif_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perif_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, status and baud divisor.
// Stores queue bytes, loads return status/divisor on a combinational read path.
module perif_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        perif_sel,
    input  logic [31:0] mem_address,
    input  logic        mem_write_en,
    input  logic        mem_read,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        rdata_oe,
    output logic        tx_out,
    output logic        irq_empty
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  ovf;
    logic [DIV_WIDTH-1:0]  baud_div;
    logic [DIV_WIDTH-1:0]  cur_div;
    logic [DIV_WIDTH-1:0]  timer;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;

    logic [1:0]  offset;
    logic        wr_en;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        empty;
    logic        full;
    logic        busy;
    logic        bit_done;
    logic [7:0]  head;
    logic [31:0] count32;
    logic [3:0]  cnt4;
    logic [63:0] status;
    logic        unused_bits;

    assign offset   = mem_address[4:3];
    assign wr_en    = perif_sel & mem_write_en;
    assign push_req = wr_en & (offset == 2'd0);
    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign busy     = (state != IDLE);
    assign bit_done = (timer == cur_div - DIV_WIDTH'(1));
    assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
    // A full FIFO still accepts a push when the FSM frees a slot on that edge.
    assign push_ok  = push_req & (~full | pop);
    assign head     = fifo_mem[rd_ptr];
    assign irq_empty = empty & (state == IDLE);
    assign unused_bits = ^{mem_address, wdata};

    assign count32 = 32'(count);
    assign cnt4    = (count32 > 32'd15) ? 4'hF : count32[3:0];
    assign status  = {56'b0, cnt4, ovf, busy, empty, full};

    assign rdata_oe = perif_sel & mem_read & ~mem_write_en;

    always_comb begin
        rdata = '0;
        if (rdata_oe) begin
            unique case (offset)
                2'd1:    rdata = status;
                2'd2:    rdata = 64'(baud_div);
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok & ~pop)      count <= count + CW'(1);
            else if (~push_ok & pop) count <= count - CW'(1);
            if (push_req & ~push_ok) begin
                ovf <= 1'b1;
            end else if (wr_en & (offset == 2'd1) & wdata[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_div <= DIV_WIDTH'(DEFAULT_DIV);
        end else if (wr_en & (offset == 2'd2)) begin
            baud_div <= (wdata[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1)
                                                     : wdata[DIV_WIDTH-1:0];
        end
    end

    // cur_div latches the divisor per bit so a mid-frame write waits for a boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx_out  <= 1'b1;
            timer   <= '0;
            cur_div <= DIV_WIDTH'(DEFAULT_DIV);
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (pop) begin
                        shift   <= head;
                        timer   <= '0;
                        cur_div <= baud_div;
                        state   <= START;
                        tx_out  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        timer   <= '0;
                        cur_div <= baud_div;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_out  <= shift[0];
                    end else begin
                        timer <= timer + DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer   <= '0;
                        cur_div <= baud_div;
                        if (bit_idx == 3'd7) begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx_out  <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        timer   <= '0;
                        cur_div <= baud_div;
                        if (pop) begin
                            shift  <= head;
                            state  <= START;
                            tx_out <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        timer <= timer + DIV_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perif_uart_tx.sv
// Bench for perif_uart_tx: queue-based line model checked every cycle,
// plus directed literal checks of registers and serial timing.
module tb_perif_uart_tx;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        perif_sel = 1'b0;
    logic [31:0] mem_address = '0;
    logic        mem_write_en = 1'b0;
    logic        mem_read = 1'b0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    logic        rdata_oe;
    logic        tx_out;
    logic        irq_empty;

    int total = 0;
    int bad = 0;

    logic [7:0] m_fifo[$];
    bit         m_line[$];
    bit         m_ovf = 1'b0;
    int         m_div = 16;

    perif_uart_tx dut (
        .clock(clock),
        .reset(reset),
        .perif_sel(perif_sel),
        .mem_address(mem_address),
        .mem_write_en(mem_write_en),
        .mem_read(mem_read),
        .wdata(wdata),
        .rdata(rdata),
        .rdata_oe(rdata_oe),
        .tx_out(tx_out),
        .irq_empty(irq_empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One serial frame expanded into per-cycle line levels.
    task automatic add_frame(input logic [7:0] b, input int d);
        bit lv;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      lv = 1'b0;
            else if (k == 9) lv = 1'b1;
            else             lv = b[k-1];
            for (int j = 0; j < d; j++) m_line.push_back(lv);
        end
    endtask

    task automatic model_step();
        logic [1:0] off;
        logic [7:0] b;
        bit wr;
        bit pop_now;
        int pre;
        off = mem_address[4:3];
        wr = perif_sel && mem_write_en;
        pre = m_fifo.size();
        pop_now = (m_line.size() <= 1) && (pre > 0);
        if (m_line.size() > 0) void'(m_line.pop_front());
        if (pop_now) begin
            b = m_fifo.pop_front();
            add_frame(b, m_div);
        end
        if (wr && off == 2'd0) begin
            if (pre < DEPTH || pop_now) m_fifo.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
        end
        if (wr && off == 2'd1 && wdata[3]) m_ovf = 1'b0;
        if (wr && off == 2'd2) m_div = (wdata[15:0] == 16'd0) ? 1 : int'(wdata[15:0]);
    endtask

    function automatic logic [63:0] exp_rd();
        int c;
        int busy;
        if (!(perif_sel && mem_read && !mem_write_en)) return 64'd0;
        busy = (m_line.size() > 0) ? 1 : 0;
        c = (m_fifo.size() > 15) ? 15 : m_fifo.size();
        case (mem_address[4:3])
            2'd1: return 64'(c * 16 + int'(m_ovf) * 8 + busy * 4
                        + ((m_fifo.size() == 0) ? 2 : 0)
                        + ((m_fifo.size() == DEPTH) ? 1 : 0));
            2'd2: return 64'(m_div);
            default: return 64'd0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_fifo.delete();
                m_line.delete();
                m_ovf = 1'b0;
                m_div = 16;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            chk("tx", tx_out, (m_line.size() > 0) ? m_line[0] : 1'b1);
            chk("irq", irq_empty, (m_fifo.size() == 0 && m_line.size() == 0));
            chk("oe", rdata_oe, perif_sel & mem_read & ~mem_write_en);
            chk("rdata", rdata, exp_rd());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic bus_wr(input logic [31:0] a, input logic [63:0] d);
        @(negedge clock);
        perif_sel = 1'b1;
        mem_write_en = 1'b1;
        mem_read = 1'b0;
        mem_address = a;
        wdata = d;
    endtask

    task automatic bus_idle();
        @(negedge clock);
        perif_sel = 1'b0;
        mem_write_en = 1'b0;
        mem_read = 1'b0;
        wdata = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [63:0] exp,
                          input string nm);
        @(negedge clock);
        perif_sel = 1'b1;
        mem_write_en = 1'b0;
        mem_read = 1'b1;
        mem_address = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!irq_empty && n < limit);
        total++;
        if (!irq_empty) begin
            bad++;
            $display("FAIL idle_timeout act=busy exp=idle t=%0t", $time);
        end
    endtask

    logic [9:0] a5_bits = 10'b11_0100_1010;

    initial begin
        int e;
        int first;
        int last;
        bit hit;

        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_tx", tx_out, 1'b1);
        chk("rst_irq", irq_empty, 1'b1);
        chk("rst_oe", rdata_oe, 1'b0);
        bus_rd(32'h08, 64'h02, "rst_status");
        bus_rd(32'h10, 64'd16, "rst_baud");

        bus_wr(32'h10, 64'd4);
        bus_wr(32'h00, 64'hA5);
        bus_idle();
        #1;
        chk("a5_pre", tx_out, 1'b1);
        e = 0;
        for (int k = 0; k < 10; k++) begin
            while (e < 4 * k + 2) begin
                @(posedge clock);
                e++;
            end
            #1;
            chk($sformatf("a5_bit%0d", k), tx_out, a5_bits[k]);
        end
        while (e < 40) begin
            @(posedge clock);
            e++;
        end
        #1;
        chk("a5_irq40", irq_empty, 1'b0);
        @(posedge clock);
        #1;
        chk("a5_irq41", irq_empty, 1'b1);

        bus_wr(32'h00, 64'hFF);
        for (int i = 0; i < 9; i++) bus_wr(32'h00, 64'(i));
        bus_rd(32'h08, 64'h8D, "ovf_status");
        bus_wr(32'h08, 64'h8);
        bus_rd(32'h08, 64'h85, "ovf_clear");

        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clock);
            if (m_line.size() == 1) hit = 1'b1;
        end
        chk("pop_push_sync", hit, 1'b1);
        perif_sel = 1'b1;
        mem_write_en = 1'b1;
        mem_read = 1'b0;
        mem_address = 32'h00;
        wdata = 64'h5A;
        bus_rd(32'h08, 64'h85, "full_pop_push");
        bus_idle();
        wait_idle(1000);

        bus_wr(32'h00, 64'h3C);
        bus_idle();
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_tx", tx_out, 1'b1);
        chk("abort_irq", irq_empty, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bus_rd(32'h08, 64'h02, "abort_status");
        bus_rd(32'h10, 64'd16, "abort_baud");
        bus_idle();
        repeat (20) @(posedge clock);
        bus_wr(32'h00, 64'h81);
        bus_idle();
        wait_idle(400);

        bus_wr(32'h10, 64'd0);
        bus_rd(32'h10, 64'd1, "baud_zero");
        bus_wr(32'h00, 64'h33);
        bus_idle();
        first = -1;
        last = -1;
        for (int i = 1; i < 60 && last < 0; i++) begin
            @(posedge clock);
            #1;
            if (first < 0 && tx_out == 1'b0) first = i;
            if (irq_empty) last = i;
        end
        chk("frame_len_div1", 64'(last - first), 64'd10);

        bus_rd(32'h18, 64'd0, "reserved_rd");
        @(negedge clock);
        perif_sel = 1'b0;
        mem_read = 1'b1;
        mem_address = 32'h10;
        #1;
        chk("nosel_rdata", rdata, 64'd0);
        chk("nosel_oe", rdata_oe, 1'b0);
        @(negedge clock);
        perif_sel = 1'b1;
        mem_read = 1'b1;
        mem_write_en = 1'b1;
        mem_address = 32'h08;
        wdata = 64'h0;
        #1;
        chk("rdwr_oe", rdata_oe, 1'b0);
        bus_idle();
        repeat (3) @(posedge clock);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
